ifu_fetch: RTL

Instruction fetch stage directly upstream of the decoder.
- Holds the architectural PC.
- Issues one 32-bit instruction read per instruction on an AXI4-Lite-style read channel (AR/R).
- Presents the fetched word to the decoder through a valid/ready handshake.
- Waits for the next PC from the writeback/commit path before fetching again. There is one instruction in flight; the core is multi-cycle, not pipelined.

---
 rtl/ifu_fetch_if.sv | 28 ++
 rtl/ifu_fetch.sv | 83 ++++++++
 2 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: AR/R instruction read channel, decoder handshake
// and the next-PC return path from commit.
interface ifu_fetch_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] ifu_instruction;
  logic [31:0] ifu_pc;
  logic        ifu_fault;
  logic        ifu_valid;
  logic        idu_ready;
  logic        npc_valid;
  logic [31:0] npc;

  modport master (
    output araddr, arvalid, rready, ifu_instruction, ifu_pc, ifu_fault, ifu_valid,
    input  arready, rdata, rresp, rvalid, idu_ready, npc_valid, npc
  );

  modport slave (
    input  araddr, arvalid, rready, ifu_instruction, ifu_pc, ifu_fault, ifu_valid,
    output arready, rdata, rresp, rvalid, idu_ready, npc_valid, npc
  );
endinterface

// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch: one AR/R read per instruction, hands the word
// to the decoder, then idles until commit returns the next PC.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] FAULT_INST = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  ifu_fetch_if.master   bus
);

  typedef enum logic [1:0] {FETCH, WAIT_R, OUT, WAIT_PC} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } ifu_rsp_t;

  state_t   state, state_nxt;
  logic [31:0] pc;
  ifu_rsp_t rsp;
  logic     misaligned;
  logic     rd_fault;

  assign misaligned = pc[1:0] != 2'b00;
  assign rd_fault   = bus.rresp != 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // A misaligned PC never reaches the bus; it is reported as a faulting fetch.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (misaligned) state_nxt = OUT;
               else if (bus.arready) state_nxt = WAIT_R;
      WAIT_R:  if (bus.rvalid)    state_nxt = OUT;
      OUT:     if (bus.idu_ready) state_nxt = WAIT_PC;
      WAIT_PC: if (bus.npc_valid) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // State resets to FETCH, so arvalid is masked while reset is held.
  always_comb begin
    bus.arvalid   = 1'b0;
    bus.rready    = 1'b0;
    bus.ifu_valid = 1'b0;
    case (state)
      FETCH:   bus.arvalid   = rst_n && !misaligned;
      WAIT_R:  bus.rready    = 1'b1;
      OUT:     bus.ifu_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RESET_PC;
      rsp <= '0;
    end else begin
      if (state == WAIT_PC && bus.npc_valid) pc <= bus.npc;
      if (state == FETCH && misaligned) begin
        rsp.inst  <= FAULT_INST;
        rsp.pc    <= pc;
        rsp.fault <= 1'b1;
      end else if (state == WAIT_R && bus.rvalid) begin
        rsp.inst  <= rd_fault ? FAULT_INST : bus.rdata;
        rsp.pc    <= pc;
        rsp.fault <= rd_fault;
      end
    end
  end

  assign bus.araddr          = pc;
  assign bus.ifu_instruction = rsp.inst;
  assign bus.ifu_pc          = rsp.pc;
  assign bus.ifu_fault       = rsp.fault;

endmodule
